vram_dual_port: RTL and testbench
=================================

# vram_dual_port

True dual-port byte-wide video RAM with two independent read/write ports sharing a single clock. Port A is typically driven by the pixel writer (rendering/host side). Port B is typically driven by the display scan-out reader. Storage is a synchronous array with registered outputs, sized by parameter, behind a fixed 24-bit address bus.

## Interface
- `ADDR_W`, 24: address port width (bus width, fixed by system map).
- `DATA_W`, 8: data width per word.
- `DEPTH`, 4096: implemented words (addresses 0..DEPTH-1); must be ≤ 2^ADDR_W.
- `clk`  in  1  single clock for both ports; both ports are sampled and updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addra`  in  ADDR_W  port A address.
- `dina`  in  DATA_W  port A write data.
- `wea`  in  1  port A write enable.
- `douta`  out  DATA_W  port A registered read data.
- `addrb`  in  ADDR_W  port B address.
- `dinb`  in  DATA_W  port B write data.
- `web`  in  1  port B write enable.
- `doutb`  out  DATA_W  port B registered read data.

## Operation
- Each port does one access per clock: a write when `we*`=1, a read otherwise. Ports are fully independent.
- Write: on a rising edge with `we*`=1 and address < DEPTH, `mem[addr] <= din`.
- Read: every edge, `dout* <= mem[addr]`, including on write cycles.
- Read-first mode: on a port's own write cycle, `dout*` returns the old contents of that address.
- Out-of-range address (≥ DEPTH): writes are dropped, and `dout*` loads 0.
- Cross-port collision, with one port writing and the other reading the same address in the same edge: the reader gets the old data, and the new data is visible from the next access.
- Both ports writing the same address in the same edge: port A's data is stored. Port B's write is discarded.
- Memory contents are not initialised and are not cleared by reset. Verification must write before reading.

## Timing
- Reset: while `rst_n`=0, `douta` and `doutb` are 0 immediately (asynchronous). No writes occur during reset.
- Reset release: the first rising edge with `rst_n`=1 performs normal accesses.
- Reset asserted mid-operation: the outputs clear at once, and array contents written before reset are retained.
- Read latency: one cycle. An address presented before edge N has its data on `dout*` after edge N, stable until edge N+1.
- Write latency: data written at edge N can be read by either port at edge N+1 and appears on `dout` after N+1.
- No handshake: accesses are accepted every cycle, with no back-pressure or busy state.

## Structure
- Shared package `vram_pkg` holds:
  - `DATA_W` and `ADDR_W` defaults;
  - `addr_t` and `data_t` typedefs;
  - the `VRAM_OOR_DATA` constant (0), which is returned on out-of-range reads.
- One sub-module, `vram_bank`, contains:
  - the raw true-dual-port array with address decode/truncation;
  - the write-collision priority (A over B).
- The top level adds:
  - the range check;
  - the read-first output registers with asynchronous clear.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with any inputs → `douta`=`doutb`=0; after release, outputs track reads.
- Port A fill / port B readback: write addr i with data (3*i) mod 256 for i=0..19 (wea pulsed one cycle each, idle cycle between), then set `addrb`=i each 2 cycles → `doutb`=0,3,6,…,57 one cycle after each address.
- Read-first and cross-port collision: pre-load addr 5=0x11, then in the same edge write A addr5=0xAA and read B addr5 → `douta`=0x11 and `doutb`=0x11; next cycle reading addr5 on both ports gives 0xAA.
- Write-write collision: A writes addr7=0x01 and B writes addr7=0x02 in the same edge → subsequent read of addr7 = 0x01.
- Out of range: write addr `DEPTH` (e.g. 0x001000)=0x55 → no alias at addr 0, and a read of 0x001000 returns 0; write at 0xFFFFFF is likewise ignored.
- Asynchronous reset mid-stream: assert `rst_n`=0 between edges while reading addr 3 (=9) → `doutb` drops to 0 without a clock; after release, reading addr 3 returns 9 again (contents retained).

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the dual-port video RAM.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 24;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef logic [VRAM_ADDR_W-1:0] addr_t;
  typedef logic [VRAM_DATA_W-1:0] data_t;

  localparam data_t VRAM_OOR_DATA = '0;

endpackage

// File: rtl/vram_dual_port_if.sv
// Two independent byte ports of the video RAM: A (pixel writer), B (scan-out).
interface vram_dual_port_if
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              wea;
  logic [DATA_W-1:0] douta;

  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic              web;
  logic [DATA_W-1:0] doutb;

  modport master (
    output addra, dina, wea, addrb, dinb, web,
    input  douta, doutb
  );

  modport slave (
    input  addra, dina, wea, addrb, dinb, web,
    output douta, doutb
  );

endinterface

// File: rtl/vram_bank.sv
// Raw true-dual-port array: address truncation, A-over-B write priority,
// combinational read of the pre-edge contents.
module vram_bank
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] din_a_i,
  input  logic              we_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] din_b_i,
  input  logic              we_b_i,
  output logic [DATA_W-1:0] rd_b_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic              unused_addr;

  assign idx_a       = addr_a_i[IDX_W-1:0];
  assign idx_b       = addr_b_i[IDX_W-1:0];
  assign unused_addr = ^{addr_a_i, addr_b_i};

  // B is suppressed explicitly on a same-address double write so priority
  // does not depend on assignment order.
  always_ff @(posedge clk) begin
    if (we_b_i && !(we_a_i && (idx_a == idx_b))) begin
      mem_q[idx_b] <= din_b_i;
    end
    if (we_a_i) begin
      mem_q[idx_a] <= din_a_i;
    end
  end

  assign rd_a_o = mem_q[idx_a];
  assign rd_b_o = mem_q[idx_b];

endmodule

// File: rtl/vram_dual_port.sv
// True dual-port byte VRAM: range check, read-first registered outputs with
// asynchronous clear, array in vram_bank.
module vram_dual_port
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vram_dual_port_if.slave      bus
);

  logic              in_range_a;
  logic              in_range_b;
  logic              we_a;
  logic              we_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] douta_q;
  logic [DATA_W-1:0] douta_d;
  logic [DATA_W-1:0] doutb_q;
  logic [DATA_W-1:0] doutb_d;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range_a = ({1'b0, bus.addra} < (ADDR_W + 1)'(DEPTH));
  assign in_range_b = ({1'b0, bus.addrb} < (ADDR_W + 1)'(DEPTH));

  assign we_a = bus.wea & in_range_a & rst_n;
  assign we_b = bus.web & in_range_b & rst_n;

  vram_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk      (clk),
    .addr_a_i (bus.addra),
    .din_a_i  (bus.dina),
    .we_a_i   (we_a),
    .rd_a_o   (rd_a),
    .addr_b_i (bus.addrb),
    .din_b_i  (bus.dinb),
    .we_b_i   (we_b),
    .rd_b_o   (rd_b)
  );

  always_comb begin
    douta_d = DATA_W'(VRAM_OOR_DATA);
    doutb_d = DATA_W'(VRAM_OOR_DATA);
    if (in_range_a) douta_d = rd_a;
    if (in_range_b) doutb_d = rd_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

endmodule

// File: tb/tb_vram_dual_port.sv
// Directed bench for vram_dual_port with hand-computed expectations.
module tb_vram_dual_port;
  import vram_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  vram_dual_port_if #(.ADDR_W(24), .DATA_W(8)) bus ();

  vram_dual_port #(
    .ADDR_W (24),
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, passed=%0d expected=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Reset with junk on both ports
    rst_n     = 1'b0;
    bus.addra = 24'h000010; bus.dina = 8'hEE; bus.wea = 1'b1;
    bus.addrb = 24'h000011; bus.dinb = 8'hDD; bus.web = 1'b1;
    tick();
    tick();
    chk("reset_douta", bus.douta, 8'h00);
    chk("reset_doutb", bus.doutb, 8'h00);
    rst_n   = 1'b1;
    bus.wea = 1'b0;
    bus.web = 1'b0;

    // Port A fill, 3*i
    for (int i = 0; i < 20; i++) begin
      bus.addra = 24'(i);
      bus.dina  = 8'(3 * i);
      bus.wea   = 1'b1;
      tick();
      bus.wea = 1'b0;
      tick();
    end

    // Port B readback, address changes every 2 cycles
    for (int i = 0; i < 20; i++) begin
      bus.addrb = 24'(i);
      tick();
      chk("fill_rd_b", bus.doutb, 8'(3 * i));
      tick();
      chk("fill_hold_b", bus.doutb, 8'(3 * i));
    end

    bus.addra = 24'd19;
    tick();
    chk("fill_rd_a19", bus.douta, 8'd57);

    // Read-first and cross-port collision (A writes, B reads)
    bus.addra = 24'd5; bus.dina = 8'h11; bus.wea = 1'b1;
    tick();
    bus.dina = 8'hAA; bus.addrb = 24'd5;
    tick();
    chk("rdfirst_a", bus.douta, 8'h11);
    chk("xcoll_b_old", bus.doutb, 8'h11);
    bus.wea = 1'b0;
    tick();
    chk("xcoll_a_new", bus.douta, 8'hAA);
    chk("xcoll_b_new", bus.doutb, 8'hAA);

    // B writes, A reads same address (old value 18)
    bus.addra = 24'd6; bus.addrb = 24'd6; bus.dinb = 8'h66; bus.web = 1'b1;
    tick();
    chk("xcollb_a_old", bus.douta, 8'h12);
    chk("xcollb_b_old", bus.doutb, 8'h12);
    bus.web = 1'b0;
    tick();
    chk("xcollb_a_new", bus.douta, 8'h66);
    chk("xcollb_b_new", bus.doutb, 8'h66);

    // Write-write collision on addr 7 (old value 21)
    bus.addra = 24'd7; bus.dina = 8'h01; bus.wea = 1'b1;
    bus.addrb = 24'd7; bus.dinb = 8'h02; bus.web = 1'b1;
    tick();
    chk("ww_a_old", bus.douta, 8'h15);
    chk("ww_b_old", bus.doutb, 8'h15);
    bus.wea = 1'b0; bus.web = 1'b0;
    tick();
    chk("ww_a_wins", bus.douta, 8'h01);
    chk("ww_b_sees_a", bus.doutb, 8'h01);

    // Out of range at DEPTH must not alias onto addr 0
    bus.addra = 24'h001000; bus.dina = 8'h55; bus.wea = 1'b1;
    tick();
    chk("oor_wr_rd_a", bus.douta, 8'h00);
    bus.wea = 1'b0;
    bus.addra = 24'h000000;
    bus.addrb = 24'h001000;
    tick();
    chk("oor_no_alias0", bus.douta, 8'h00);
    chk("oor_rd_b", bus.doutb, 8'h00);

    // 0xFFFFFF aliases to 4095 if truncation leaks a write
    bus.addra = 24'd4095; bus.dina = 8'h42; bus.wea = 1'b1;
    tick();
    bus.addra = 24'hFFFFFF; bus.dina = 8'h77;
    bus.addrb = 24'h001003; bus.dinb = 8'h99; bus.web = 1'b1;
    tick();
    chk("oor_top_rd_a", bus.douta, 8'h00);
    chk("oor_1003_rd_b", bus.doutb, 8'h00);
    bus.wea = 1'b0; bus.web = 1'b0;
    bus.addra = 24'd4095;
    bus.addrb = 24'd3;
    tick();
    chk("oor_no_alias4095", bus.douta, 8'h42);
    chk("oor_no_alias3", bus.doutb, 8'h09);

    // Asynchronous reset mid-cycle
    tick();
    chk("pre_arst_b", bus.doutb, 8'h09);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_doutb", bus.doutb, 8'h00);
    chk("arst_douta", bus.douta, 8'h00);
    tick();
    chk("arst_hold_b", bus.doutb, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_arst_b", bus.doutb, 8'h09);
    chk("post_arst_a", bus.douta, 8'h42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
